// File: rtl/musicbox_pkg.sv
// Shared definitions for the music-box blocks: playback FSM states,
// mainState encodings and small helpers.
package musicbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_PLAY,
    ST_DONE
  } pb_state_t;

  // mainState values produced by MusicBoxStateController
  localparam logic [4:0] MS_IDLE     = 5'd0;
  localparam logic [4:0] MS_RECORD   = 5'd1;
  localparam logic [4:0] MS_STORE    = 5'd2;
  localparam logic [4:0] MS_PLAYBACK = 5'd3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/musicbox_sample_fifo.sv
// Read-ahead sample buffer: single-word push, POP_N-word show-ahead pop,
// occupancy count and synchronous flush.
module musicbox_sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned POP_N = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [POP_N*WIDTH-1:0]     pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Pointer and occupancy update; push and pop may coincide
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + AW'(POP_N);
      count <= count + CW'(push) - (pop ? CW'(POP_N) : '0);
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

  // Oldest POP_N words presented in ascending order, oldest in the LSBs
  always_comb begin
    pop_data = '0;
    for (int unsigned i = 0; i < POP_N; i++) begin
      pop_data[i*WIDTH +: WIDTH] = mem[rd_ptr + AW'(i)];
    end
  end

endmodule

// File: rtl/musicbox_playback_engine.sv
// Streams a recording from SDRAM through a read-ahead FIFO and presents
// one interleaved frame per sample_tick while mainState selects playback.
module musicbox_playback_engine
  import musicbox_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned ADDR_W     = 25,
  parameter int unsigned NUM_CH     = 1,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [4:0]  STATE_ID   = MS_PLAYBACK
) (
  input  logic                       clock_50Mhz,
  input  logic                       reset,
  input  logic [4:0]                 mainState,
  input  logic                       sample_tick,
  input  logic [ADDR_W-1:0]          start_address,
  input  logic [ADDR_W-1:0]          length_frames,
  input  logic                       loop_enable,
  output logic [NUM_CH*SAMPLE_W-1:0] outputData,
  output logic                       outputActive,
  output logic                       stateComplete,
  output logic [15:0]                underrun_count,
  output logic [ADDR_W-1:0]          sdram_inputAddress,
  output logic [15:0]                sdram_writeData,
  output logic                       sdram_isWriting,
  output logic                       sdram_inputValid,
  input  logic [15:0]                sdram_readData,
  input  logic                       sdram_outputValid,
  input  logic                       sdram_recievedCommand,
  input  logic                       sdram_isBusy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  pb_state_t state, state_next;

  logic [ADDR_W-1:0] start_lat, len_lat, total_words;
  logic [ADDR_W-1:0] fetch_addr, fetch_idx, frame_cnt;
  logic              req_valid, outstanding;
  logic [CW-1:0]     fifo_count;
  logic [NUM_CH*SAMPLE_W-1:0] fifo_pop_data;

  logic in_state, start_run, run, run_next;
  logic tick_play, fifo_push, fifo_pop, fifo_flush, starved;
  logic last_frame, fetch_done, can_issue, accept;

  assign in_state   = (mainState == STATE_ID);
  assign start_run  = in_state && (state == ST_IDLE);
  assign run        = in_state && (state == ST_PREFETCH || state == ST_PLAY);
  assign run_next   = (state_next == ST_PREFETCH) || (state_next == ST_PLAY);
  assign tick_play  = run && (state == ST_PLAY) && sample_tick;
  assign fifo_pop   = tick_play && (fifo_count >= CW'(NUM_CH));
  assign starved    = tick_play && (fifo_count < CW'(NUM_CH));
  assign fifo_push  = run && outstanding && sdram_outputValid;
  assign fifo_flush = !run;
  assign last_frame = (frame_cnt == len_lat - 1'b1);
  assign accept     = req_valid && sdram_recievedCommand;
  assign fetch_done = (fetch_idx == total_words) && !req_valid && !outstanding;
  assign can_issue  = !req_valid && !outstanding && !sdram_isBusy &&
                      (fifo_count < CW'(FIFO_DEPTH)) && (fetch_idx != total_words);

  assign sdram_inputAddress = fetch_addr;
  assign sdram_inputValid   = req_valid;
  assign sdram_writeData    = '0;
  assign sdram_isWriting    = 1'b0;

  musicbox_sample_fifo #(
    .WIDTH(SAMPLE_W),
    .DEPTH(FIFO_DEPTH),
    .POP_N(NUM_CH)
  ) u_fifo (
    .clk      (clock_50Mhz),
    .reset    (reset),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_data(SAMPLE_W'(sdram_readData)),
    .pop      (fifo_pop),
    .pop_data (fifo_pop_data),
    .count    (fifo_count)
  );

  // FSM state register
  always_ff @(posedge clock_50Mhz) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic; losing mainState always returns to IDLE
  always_comb begin
    state_next = state;
    if (!in_state) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:     state_next = (length_frames == '0) ? ST_DONE : ST_PREFETCH;
        ST_PREFETCH: if (fifo_count == CW'(FIFO_DEPTH) || fetch_done) state_next = ST_PLAY;
        ST_PLAY:     if (fifo_pop && last_frame && !loop_enable) state_next = ST_DONE;
        ST_DONE:     state_next = ST_DONE;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  // FSM status outputs
  always_comb begin
    outputActive  = (state == ST_PLAY);
    stateComplete = (state == ST_DONE);
  end

  // Fetch engine: one read in flight, request held until accepted,
  // address wraps to the latched start when looping
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      req_valid   <= 1'b0;
      outstanding <= 1'b0;
      fetch_addr  <= '0;
      fetch_idx   <= '0;
    end else if (start_run) begin
      req_valid   <= 1'b0;
      outstanding <= 1'b0;
      fetch_addr  <= start_address;
      fetch_idx   <= '0;
    end else if (!run_next) begin
      req_valid   <= 1'b0;
      outstanding <= 1'b0;
    end else if (run) begin
      if (accept) begin
        req_valid   <= 1'b0;
        outstanding <= 1'b1;
        if (fetch_idx == total_words - 1'b1 && loop_enable) begin
          fetch_idx  <= '0;
          fetch_addr <= start_lat;
        end else begin
          fetch_idx  <= fetch_idx + 1'b1;
          fetch_addr <= fetch_addr + 1'b1;
        end
      end else if (can_issue) begin
        req_valid <= 1'b1;
      end
      if (fifo_push) outstanding <= 1'b0;
    end
  end

  // Playback datapath: run parameters, frame output, frame counter, underruns
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      start_lat      <= '0;
      len_lat        <= '0;
      total_words    <= '0;
      frame_cnt      <= '0;
      outputData     <= '0;
      underrun_count <= '0;
    end else begin
      if (start_run) begin
        start_lat   <= start_address;
        len_lat     <= length_frames;
        total_words <= length_frames * ADDR_W'(NUM_CH);
        frame_cnt   <= '0;
      end
      if (fifo_pop) begin
        outputData <= fifo_pop_data;
        frame_cnt  <= last_frame ? '0 : frame_cnt + 1'b1;
      end
      if (starved) underrun_count <= sat_inc16(underrun_count);
    end
  end

endmodule
